// File: rtl/bcd_score_keeper.sv
// N-digit BCD score accumulator with high-score latch and registered active-low 7-segment outputs.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks display digits above the highest nonzero digit.
module bcd_score_keeper #(
  parameter int DIGITS = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  gameTick,
  input  logic                  enable,
  input  logic [3:0]            points,
  input  logic                  game_over,
  input  logic                  show_high,
  output logic [DIGITS*4-1:0]   score,
  output logic [DIGITS*4-1:0]   high_score,
  output logic                  saturated,
  output logic                  new_high,
  output logic [DIGITS*7-1:0]   HEX
);

  localparam int W  = DIGITS * 4;
  localparam int HW = DIGITS * 7;

  logic [W-1:0]  score_r;
  logic [W-1:0]  high_r;
  logic          sat_r;
  logic          new_high_r;
  logic [HW-1:0] hex_r;

  logic [3:0]    pts_s;
  logic          accept_s;
  logic [W-1:0]  sum_s;
  logic          cout_s;
  logic [W-1:0]  disp_s;
  logic          beat_high_s;

  // One BCD digit plus carry-in; returns {cout, digit}
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] d, input logic [3:0] cin);
    logic [4:0] sum;
    logic [4:0] adj;
    sum = {1'b0, d} + {1'b0, cin};
    adj = sum - 5'd10;
    if (sum > 5'd9) begin
      return {1'b1, adj[3:0]};
    end else begin
      return {1'b0, sum[3:0]};
    end
  endfunction

  // Active-low segment pattern, bit 0 = a ... bit 6 = g; invalid codes blank
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Full display encoding of a packed BCD value; digit 0 is never blanked
  function automatic logic [HW-1:0] encode_display(input logic [W-1:0] v);
    logic [HW-1:0] h;
    int            top;
    h   = {HW{1'b1}};
    top = 0;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[k*4 +: 4] != 4'd0) begin
        top = k;
      end else begin
        top = top;
      end
    end
    for (int k = 0; k < DIGITS; k++) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (k > top) begin
        h[k*7 +: 7] = 7'b1111111;
      end else begin
        h[k*7 +: 7] = seg_of(v[k*4 +: 4]);
      end
`else
      h[k*7 +: 7] = seg_of(v[k*4 +: 4]);
`endif
    end
    return h;
  endfunction

  // Clamp points, qualify the tick and ripple the add across all digits
  always_comb begin
    logic [3:0] cin_v;
    logic [4:0] r_v;
    pts_s    = (points > 4'd9) ? 4'd9 : points;
    accept_s = gameTick & enable & ~clear & ~reset;
    sum_s    = {W{1'b0}};
    cin_v    = pts_s;
    for (int k = 0; k < DIGITS; k++) begin
      r_v            = bcd_digit_add(score_r[k*4 +: 4], cin_v);
      sum_s[k*4 +: 4] = r_v[3:0];
      cin_v          = {3'b000, r_v[4]};
    end
    cout_s      = cin_v[0];
    beat_high_s = game_over & (score_r > high_r);
    disp_s      = show_high ? high_r : score_r;
  end

  // Score, high score and flags; game_over sees the pre-edge score
  always_ff @(posedge clock) begin
    if (reset) begin
      score_r    <= {W{1'b0}};
      high_r     <= {W{1'b0}};
      sat_r      <= 1'b0;
      new_high_r <= 1'b0;
    end else begin
      if (beat_high_s) begin
        high_r     <= score_r;
        new_high_r <= 1'b1;
      end else begin
        new_high_r <= 1'b0;
      end
      if (clear) begin
        score_r <= {W{1'b0}};
        sat_r   <= 1'b0;
      end else if (accept_s) begin
        if (cout_s) begin
          score_r <= {DIGITS{4'h9}};
          sat_r   <= 1'b1;
        end else begin
          score_r <= sum_s;
        end
      end
    end
  end

  // Display register follows the already-updated score/high_score by one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      hex_r <= encode_display({W{1'b0}});
    end else begin
      hex_r <= encode_display(disp_s);
    end
  end

  assign score      = score_r;
  assign high_score = high_r;
  assign saturated  = sat_r;
  assign new_high   = new_high_r;
  assign HEX        = hex_r;

endmodule

// File: doc/bcd_score_keeper.md
# bcd_score_keeper

Parametrised N-digit BCD score accumulator with high-score tracking and registered seven-segment outputs. It adds a per-tick point value (0–9) to the running score, saturates at all-nines, and latches a high score at game over. It drives the board HEX displays in place of the fixed six-digit, +1-only score counter. Score and high score are both exposed as packed BCD for other game logic.

## Interface
- DIGITS, 6, number of BCD digits and displays; legal range 1–8.
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- clear  in  1  new-game strobe; clears score and saturated, keeps high_score.
- gameTick  in  1  scoring strobe, one cycle per event.
- enable  in  1  gameTick is accepted only while high.
- points  in  4  value added per accepted tick; 10–15 clamp to 9.
- game_over  in  1  strobe; compares score against high_score.
- show_high  in  1  display select: 0 shows score, 1 shows high_score.
- score  out  DIGITS*4  running score, packed BCD, digit 0 in [3:0].
- high_score  out  DIGITS*4  best score, packed BCD.
- saturated  out  1  sticky; set when an add clamps at all-nines.
- new_high  out  1  one-cycle pulse when high_score is replaced.
- HEX  out  DIGITS*7  active-low segments for common-anode displays; digit k in [7k+6:7k]; bit 0 = a … bit 6 = g.

## Operation
- Accepted tick: gameTick & enable & !clear & !reset.
- Add: pts = min(points, 9). It is added to digit 0. Each digit computes sum = d + cin; if sum > 9, it keeps sum − 10 and sets cout. The carry ripples across all digits in the same cycle. pts = 0 is a legal no-op add.
- Saturation: if the most significant digit produces cout, score becomes all 9s and saturated is set. saturated stays high until clear or reset.
- At saturation, further ticks leave score at all 9s.
- Game over: if game_over and score > high_score, high_score <= score and new_high pulses the next cycle. Packed BCD compares as an unsigned integer. Equal scores do not update.
- Priority within one cycle, highest first:
  - reset;
  - clear;
  - accepted tick.
- game_over is evaluated on the pre-edge score. It is independent of clear and tick, so game_over and clear together save the old score, then clear it.
- Display: each digit is decoded 0–9 to the standard pattern; 0 = 7'b1000000, 8 = 7'b0000000. Codes 10–15 cannot occur; if forced, the digit is blanked (7'b1111111).
- Source for the display: high_score when show_high = 1, else score.

## Timing
- Reset values:
  - score = 0, high_score = 0;
  - saturated = 0, new_high = 0;
  - HEX = digit 0 shows "0"; other digits show "0", or are blanked when LEADING_ZERO_BLANK_EN is defined.
- score and high_score update on the edge that samples the strobe, so they are visible in the next cycle.
- new_high is asserted in the same cycle that high_score shows the new value.
- HEX is registered from the post-update values: 1 cycle after score/high_score, so 2 cycles from the gameTick edge.
- A show_high change appears on HEX after 1 cycle.
- Back-to-back ticks on every cycle are each accepted. There is no lost carry and no busy state.
- Reset or clear asserted mid-stream takes effect on that edge. A tick in the same cycle is dropped.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: every digit above the highest nonzero digit outputs 7'b1111111. Digit 0 is never blanked, so a zero value shows a single "0".
  - Undefined: all DIGITS digits are always displayed, including leading zeros.
  - The macro has no effect on score, high_score or the flags.

## Test plan
- Reset, then 12 ticks with points=1, enable=1 -> score=0x000012; HEX0=7'b0100100 ("2"), HEX1=7'b1111001 ("1") two cycles after the last tick.
- score=0x000095, tick with points=7 -> 0x000102; tick with points=15 -> 0x000111 (clamped to 9).
- DIGITS=2, score=0x98, tick with points=5 -> score=0x99, saturated=1; clear -> score=0x00, saturated=0.
- score=0x000450, high_score=0x000300, game_over and clear in the same cycle -> high_score=0x000450, new_high=1 for 1 cycle, score=0; a second game_over with score 0 -> no pulse.
- Ticks with enable=0 -> no change. Tick, clear and reset together -> all state 0.
- score=0x000042, show_high=1, high_score=0x000007:
  - with LEADING_ZERO_BLANK_EN: HEX0="7", HEX1–HEX5=7'b1111111;
  - without the macro: HEX1–HEX5="0".
